// File: rtl/sbox_pipe_pkg.sv
// Shared types and constants for the pipelined AES S-box engine.
// SBOX_PIPE_MID_REG_EN selects the 3-stage build (extra inverter register).
package sbox_pipe_pkg;

    typedef enum logic {
        SBOX_FWD = 1'b0,
        SBOX_INV = 1'b1
    } sbox_mode_e;

    localparam int BYTE_W = 8;

`ifdef SBOX_PIPE_MID_REG_EN
    localparam int PIPE_LAT = 3;
`else
    localparam int PIPE_LAT = 2;
`endif

    // Known answers, four lanes packed lane 3 .. lane 0.
    localparam logic [31:0] KAT_FWD_IN  = 32'h5301_00FF;
    localparam logic [31:0] KAT_FWD_OUT = 32'hED7C_6316;
    localparam logic [31:0] KAT_INV_IN  = 32'hED7C_6316;
    localparam logic [31:0] KAT_INV_OUT = 32'h5301_00FF;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[BYTE_W-2:0], 1'b0} ^ (aa[BYTE_W-1] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/sbox_pipe_lane.sv
// One byte lane of the S-box engine, purely combinational, in three parts:
//   top    : mode-selected input layer (identity / inverse affine)
//   invert : GF(2^8) inversion via the GF(2^4) subfield norm N = a^17,
//            split into a front half (a^16 and N^-1) and a back half
//            (a^-1 = a^16 * N^-1) so a register can sit between them
//   bottom : mode-selected output layer (forward affine / identity)
module sbox_lane
    import sbox_pipe_pkg::*;
(
    input  sbox_mode_e        top_mode_i,
    input  logic [BYTE_W-1:0] top_in_i,
    output logic [BYTE_W-1:0] top_o,
    input  logic [BYTE_W-1:0] lin_i,
    output logic [BYTE_W-1:0] frob_o,
    output logic [BYTE_W-1:0] ninv_o,
    input  sbox_mode_e        bot_mode_i,
    input  logic [BYTE_W-1:0] frob_i,
    input  logic [BYTE_W-1:0] ninv_i,
    output logic [BYTE_W-1:0] bot_o
);

    logic [BYTE_W-1:0] a2, a4, a8, n, n2, n4, n8, n12;
    logic [BYTE_W-1:0] inv_w;

    function automatic logic [BYTE_W-1:0] rotl(input logic [BYTE_W-1:0] v, input int k);
        return (v << k) | (v >> (BYTE_W - k));
    endfunction

    function automatic logic [BYTE_W-1:0] aff_fwd(input logic [BYTE_W-1:0] b);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [BYTE_W-1:0] aff_inv(input logic [BYTE_W-1:0] s);
        return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
    endfunction

    // Input layer: inverse S-box undoes the affine map before inversion.
    always_comb begin
        top_o = (top_mode_i == SBOX_INV) ? aff_inv(top_in_i) : top_in_i;
    end

    // Inverter front half: a^16 and the subfield inverse N^-1 = N^14.
    always_comb begin
        a2     = gf_mul(lin_i, lin_i);
        a4     = gf_mul(a2, a2);
        a8     = gf_mul(a4, a4);
        frob_o = gf_mul(a8, a8);
        n      = gf_mul(frob_o, lin_i);
        n2     = gf_mul(n, n);
        n4     = gf_mul(n2, n2);
        n8     = gf_mul(n4, n4);
        n12    = gf_mul(n8, n4);
        ninv_o = gf_mul(n12, n2);
    end

    // Inverter back half and output layer; zero maps to zero naturally.
    always_comb begin
        inv_w = gf_mul(frob_i, ninv_i);
        bot_o = (bot_mode_i == SBOX_FWD) ? aff_fwd(inv_w) : inv_w;
    end

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane pipelined AES S-box engine with valid/ready and a sideband tag.
// Whole-pipe stall: every stage advances together when the output is free.
// Define SBOX_PIPE_MID_REG_EN to register the inverter intermediates
// (stage S1b), giving 3-cycle latency instead of 2.
module sbox_pipe
    import sbox_pipe_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_mode,
    input  logic [BYTE_W*LANES-1:0] in_data,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*LANES-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_mode,
    output logic                    busy
);

    localparam int DW = BYTE_W * LANES;

    logic             adv;
    sbox_mode_e       in_mode_e;

    logic             vld1_q, vld1_d;
    sbox_mode_e       mode1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [DW-1:0]    lin1_q;

    logic [DW-1:0]    top_w, frob_w, ninv_w, bot_w;

    // Signals feeding the output stage (from S1 or S1b depending on build).
    logic             vld_s;
    sbox_mode_e       mode_s;
    logic [TAG_W-1:0] tag_s;
    logic [DW-1:0]    frob_s, ninv_s;

    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    sbox_mode_e       out_mode_q;

`ifdef SBOX_PIPE_MID_REG_EN
    logic             vld1b_q, vld1b_d;
    sbox_mode_e       mode1b_q;
    logic [TAG_W-1:0] tag1b_q;
    logic [DW-1:0]    frob1b_q, ninv1b_q;
`endif

    assign in_mode_e = sbox_mode_e'(in_mode);

    // Global advance: the pipe moves only when the output slot can drain.
    always_comb begin
        adv = ~out_valid_q | out_ready;
    end

    assign in_ready = adv;

    // Next-state for all stage valid bits; a stall freezes bubbles too.
    always_comb begin
        vld1_d      = vld1_q;
        out_valid_d = out_valid_q;
`ifdef SBOX_PIPE_MID_REG_EN
        vld1b_d     = vld1b_q;
`endif
        if (adv) begin
            vld1_d      = in_valid;
            out_valid_d = vld_s;
`ifdef SBOX_PIPE_MID_REG_EN
            vld1b_d     = vld1_q;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            sbox_lane u_lane (
                .top_mode_i (in_mode_e),
                .top_in_i   (in_data[gi*BYTE_W +: BYTE_W]),
                .top_o      (top_w[gi*BYTE_W +: BYTE_W]),
                .lin_i      (lin1_q[gi*BYTE_W +: BYTE_W]),
                .frob_o     (frob_w[gi*BYTE_W +: BYTE_W]),
                .ninv_o     (ninv_w[gi*BYTE_W +: BYTE_W]),
                .bot_mode_i (mode_s),
                .frob_i     (frob_s[gi*BYTE_W +: BYTE_W]),
                .ninv_i     (ninv_s[gi*BYTE_W +: BYTE_W]),
                .bot_o      (bot_w[gi*BYTE_W +: BYTE_W])
            );
        end
    endgenerate

    // ---- S1: input linear layer output, mode and tag ----
    // S1 valid bit.
    always_ff @(posedge clk) begin
        if (rst) vld1_q <= 1'b0;
        else     vld1_q <= vld1_d;
    end

    // S1 payload; no reset needed, qualified by vld1_q.
    always_ff @(posedge clk) begin
        if (adv) begin
            lin1_q  <= top_w;
            mode1_q <= in_mode_e;
            tag1_q  <= in_tag;
        end
    end

`ifdef SBOX_PIPE_MID_REG_EN
    // ---- S1b: registered inverter intermediates ----
    // S1b valid bit.
    always_ff @(posedge clk) begin
        if (rst) vld1b_q <= 1'b0;
        else     vld1b_q <= vld1b_d;
    end

    // S1b payload: a^16 and subfield inverse per lane.
    always_ff @(posedge clk) begin
        if (adv) begin
            frob1b_q <= frob_w;
            ninv1b_q <= ninv_w;
            mode1b_q <= mode1_q;
            tag1b_q  <= tag1_q;
        end
    end

    assign vld_s  = vld1b_q;
    assign mode_s = mode1b_q;
    assign tag_s  = tag1b_q;
    assign frob_s = frob1b_q;
    assign ninv_s = ninv1b_q;
    assign busy   = vld1_q | vld1b_q | out_valid_q;
`else
    assign vld_s  = vld1_q;
    assign mode_s = mode1_q;
    assign tag_s  = tag1_q;
    assign frob_s = frob_w;
    assign ninv_s = ninv_w;
    assign busy   = vld1_q | out_valid_q;
`endif

    // ---- S2: S-box result; held stable while stalled ----
    // Output register with reset so idle outputs read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_mode_q  <= SBOX_FWD;
        end else begin
            out_valid_q <= out_valid_d;
            if (adv) begin
                out_data_q <= bot_w;
                out_tag_q  <= tag_s;
                out_mode_q <= mode_s;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_sbox_pipe.sv
// Scoreboard bench for sbox_pipe: accepted beats are predicted from a table
// model built from GF(2^8) brute-force inversion and the FIPS-197 affine map.
module tb_sbox_pipe;
    import sbox_pipe_pkg::*;

    localparam int LANES = 4;
    localparam int TAG_W = 4;
    localparam int DW    = LANES * 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [DW-1:0]    in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_mode;
    logic             busy;

    always #5 clk = ~clk;

    sbox_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_mode  (out_mode),
        .busy      (busy)
    );

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             mode;
    } beat_t;

    beat_t      exp_q[$];
    int         n_vec   = 0;
    int         n_err   = 0;
    int         acc_cnt = 0;
    int         rdy_mode = 2;   // 0: always ready, 1: random, 2: never ready
    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    // Schoolbook polynomial product followed by explicit reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int d = 14; d >= 8; d--)
            if (p[d]) p = p ^ (15'(9'h11B) << (d - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_affine(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] r;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_tbl[x] = ref_affine(inv);
        end
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
    endtask

    function automatic beat_t model(input logic [DW-1:0] d, input logic [TAG_W-1:0] t,
                                    input logic m);
        beat_t b;
        for (int i = 0; i < LANES; i++)
            b.data[i*8 +: 8] = m ? inv_tbl[d[i*8 +: 8]] : fwd_tbl[d[i*8 +: 8]];
        b.tag  = t;
        b.mode = m;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Accept tracker: predicts the result of every beat the DUT takes.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data, in_tag, in_mode));
            acc_cnt++;
        end
    end

    // Monitor: compares every emitted beat and output stability under stall.
    beat_t prev_out;
    logic  stalled = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                check("hold_data", 64'(out_data), 64'(prev_out.data));
                check("hold_tag",  64'(out_tag),  64'(prev_out.tag));
                check("hold_mode", 64'(out_mode), 64'(prev_out.mode));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_beat: got tag %0h data %0h, required no beat", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_tag",  64'(out_tag),  64'(e.tag));
                    check("out_mode", 64'(out_mode), 64'(e.mode));
                end
            end
            stalled  <= out_valid && !out_ready;
            prev_out <= '{data: out_data, tag: out_tag, mode: out_mode};
        end
    end

    task automatic send(input logic m, input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
        int g = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, g);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_out: out_valid=0 after %0d cycles, required 1", cnt);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int a0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        in_data  = '0;
        in_tag   = '0;
        build_tables();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_out_mode",  64'(out_mode),  64'd0);

        // Forward known answer and latency.
        rdy_mode = 0;
        @(posedge clk);
        #2;
        send(1'b0, KAT_FWD_IN, 4'h5);
        wait_out(lat);
        check("fwd_latency", 64'(lat), 64'(PIPE_LAT));
        check("fwd_kat",     64'(out_data), 64'h0000_0000_ED7C_6316);
        check("fwd_kat_tag", 64'(out_tag), 64'h5);

        // Inverse known answer, then alternating modes back to back.
        @(posedge clk);
        #2;
        send(1'b1, KAT_INV_IN, 4'h6);
        wait_out(lat);
        check("inv_kat", 64'(out_data), 64'h0000_0000_5301_00FF);
        @(posedge clk);
        #2;
        for (int i = 0; i < 20; i++)
            send(1'(i % 2), $urandom, 4'(i));
        drain();

        // Exhaustive: every byte through both directions.
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 64; k++)
                send(1'(m), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 4'(k));
        drain();

        // Random backpressure: tag order 0..9 enforced by the scoreboard queue.
        rdy_mode = 1;
        for (int t = 0; t < 10; t++)
            send(1'($urandom_range(0, 1)), $urandom, 4'(t));
        drain();

        // Full stall with a continuously valid input.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        repeat (6) begin
            in_valid = 1'b1;
            in_mode  = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_tag   = 4'($urandom);
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        check("stall_in_ready",  64'(in_ready),  64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_busy",      64'(busy),      64'd1);
        rdy_mode = 0;
        a0 = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_mode  = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_tag   = 4'($urandom);
            @(posedge clk);
            #2;
            if (i == 1) a0 = acc_cnt;
        end
        in_valid = 1'b0;
        check("resume_rate", 64'(acc_cnt - a0), 64'd8);
        drain();

        // Reset with two beats in flight.
        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(1'b0, $urandom, 4'hA);
        send(1'b1, $urandom, 4'hB);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_busy",      64'(busy),      64'd0);
        check("mrst_in_ready",  64'(in_ready),  64'd1);
        rdy_mode = 0;
        repeat (6) begin
            @(negedge clk);
            check("mrst_no_stale", 64'(out_valid), 64'd0);
        end

        drain();
        check("final_busy", 64'(busy), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
